fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Arbitrates framebuffer RAM write port A between two write requesters: req A is the UART line writer (control path), req B is the debug-command writer.
- Round-robin grants with burst hold and a burst cap. Registered RAM drive towards multimem port A.
- Optionally manages a double-buffered framebuffer: writes go to the back bank, and bank swaps happen only at frame boundaries signalled by the scan side.

Parameters:
- ADDR_WIDTH, 12, requester byte-address width.
- DATA_WIDTH, 8, write data width.
- MAX_BURST, 64, max writes per grant before forced release when the other requester waits; 1..255.

Ports:
- clk_in  in  1  system clock (clk_root domain).
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  requester A wants the port; held for the whole burst.
- wr_valid_a  in  1  A presents a write this cycle; honoured only while grant_a=1.
- wr_last_a  in  1  A's final write of the burst; qualified by wr_valid_a.
- addr_a  in  ADDR_WIDTH  A's write address.
- data_a  in  DATA_WIDTH  A's write data.
- grant_a  out  1  A owns the port.
- req_b, wr_valid_b, wr_last_b, addr_b, data_b, grant_b: same as A, for requester B.
- frame_start  in  1  one-cycle pulse from scan when row address wraps to 0.
- swap_request  in  1  one-cycle pulse requesting a bank swap.
- swap_pending  out  1  swap requested, not yet applied.
- display_bank  out  1  bank the fetch side reads; drives the fetch address MSB.
- ram_address  out  ADDR_WIDTH+1  {bank, addr}.
- ram_data_out  out  DATA_WIDTH  write data to RAM.
- ram_write_enable  out  1  write strobe.
- ram_clk_enable  out  1  port A clock enable; equals ram_write_enable.

Behaviour:
- Reset (async, active-high): state=IDLE; grant_a=grant_b=0; ram_address=0; ram_data_out=0; ram_write_enable=ram_clk_enable=0; swap_pending=0; display_bank=0; last_served=B, so A wins the first tie; burst counter=0.
- FSM states: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - Only req_a -> GRANT_A.
  - Only req_b -> GRANT_B.
  - Both -> the requester not equal to last_served.
  - Neither -> stay in IDLE.
- grant_x is registered and high exactly while state==GRANT_x. It rises 1 cycle after the req is sampled in IDLE.
- In GRANT_x, each cycle with wr_valid_x=1:
  - Next cycle, ram_write_enable=1, ram_address={write_bank, addr_x}, ram_data_out=data_x. Fixed 1-cycle latency.
  - Burst counter increments.
- wr_valid of the non-granted requester is ignored; its write is dropped, not queued.
- Leave GRANT_x -> IDLE, with grant cleared next cycle, when any of these holds:
  - wr_valid_x && wr_last_x, after that write is issued.
  - req_x==0.
  - Counter reaches MAX_BURST and the other req==1.
  - On exit: last_served=x, counter cleared.
- Counter saturates at MAX_BURST if the other requester is idle; the burst continues.
- At least one IDLE cycle separates consecutive grants, even for the same requester.
- ram_write_enable is low in every cycle without an issued write; ram_address and ram_data_out hold their last values.
- Reset mid-burst: everything returns to reset values immediately. The in-flight write is lost.

Optional Feature:
- Macro DOUBLE_BUFFER_EN.
- Defined:
  - write_bank = ~display_bank.
  - swap_request sets swap_pending.
  - On a frame_start while swap_pending=1 and state==IDLE: display_bank toggles, swap_pending clears.
  - If a grant is active at frame_start, the swap defers to a later frame_start; it never splits a burst across banks.
  - swap_request and frame_start in the same cycle: request latched, applied at the next frame_start.
  - swap_request while already pending: no effect.
- Undefined:
  - display_bank=0, write_bank=0, swap_pending=0 constant.
  - swap_request and frame_start are ignored.
  - ram_address MSB=0.

Test Plan:
- Reset released, req_a=1, three writes (addr 0x010..0x012, data 0x11..0x33, last on third) -> grant_a 1 cycle after req; three ram_write_enable pulses each 1 cycle after wr_valid with matching addr/data; grant_a drops after the third write.
- req_a and req_b both asserted from IDLE after reset -> A granted first; after A's last, one IDLE cycle, then grant_b.
- MAX_BURST=4, A streams 10 writes without last while req_b=1 -> exactly 4 writes issued, A released, B granted; A regranted after B finishes.
- wr_valid_b=1 while grant_a=1 -> no write from B appears on the RAM port.
- DOUBLE_BUFFER_EN: swap_request, then frame_start during A's burst -> display_bank stays 0, swap_pending=1; next frame_start in IDLE -> display_bank=1, swap_pending=0; subsequent writes have ram_address MSB=0.
- Assert reset mid-burst -> grant_a, ram_write_enable, swap_pending, display_bank all 0 on the same cycle.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Purpose: round-robin arbiter for framebuffer RAM write port A (req A = UART line writer, req B = debug writer).
// Latency: grant 1 cycle after request sampled in IDLE; each accepted write reaches the RAM port 1 cycle later.
// Backpressure: none on writes; non-granted writes are dropped. Optional bank swapping under DOUBLE_BUFFER_EN.
module fb_write_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  wr_valid_a,
    input  logic                  wr_last_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic                  grant_a,
    input  logic                  req_b,
    input  logic                  wr_valid_b,
    input  logic                  wr_last_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  grant_b,
    input  logic                  frame_start,
    input  logic                  swap_request,
    output logic                  swap_pending,
    output logic                  display_bank,
    output logic [ADDR_WIDTH:0]   ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  ram_write_enable,
    output logic                  ram_clk_enable
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);
    localparam logic SERVED_A = 1'b0;
    localparam logic SERVED_B = 1'b1;

    state_t                state_q, state_d;
    logic                  last_served_q, last_served_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  write_bank;

    logic                  sel_valid, sel_last, sel_req, other_req;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [7:0]            cnt_next;

`ifdef DOUBLE_BUFFER_EN
    logic swap_pending_q, swap_pending_d;
    logic display_bank_q, display_bank_d;

    // Latch swap requests; flip banks only at a frame boundary with no burst in flight
    always_comb begin
        swap_pending_d = swap_pending_q;
        display_bank_d = display_bank_q;
        if (frame_start && swap_pending_q && (state_q == IDLE)) begin
            display_bank_d = ~display_bank_q;
            swap_pending_d = 1'b0;
        end else if (swap_request) begin
            swap_pending_d = 1'b1;
        end
    end

    // Bank state registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            swap_pending_q <= 1'b0;
            display_bank_q <= 1'b0;
        end else begin
            swap_pending_q <= swap_pending_d;
            display_bank_q <= display_bank_d;
        end
    end

    assign swap_pending = swap_pending_q;
    assign display_bank = display_bank_q;
    assign write_bank   = ~display_bank_q;
`else
    logic unused_swap_inputs;
    assign unused_swap_inputs = swap_request ^ frame_start;
    assign swap_pending = 1'b0;
    assign display_bank = 1'b0;
    assign write_bank   = 1'b0;
`endif

    // Mux the granted requester's signals so both grant states share one path
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_req   = 1'b0;
        other_req = 1'b0;
        sel_addr  = addr_a;
        sel_data  = data_a;
        if (state_q == GRANT_A) begin
            sel_valid = wr_valid_a;
            sel_last  = wr_last_a;
            sel_req   = req_a;
            other_req = req_b;
        end else if (state_q == GRANT_B) begin
            sel_valid = wr_valid_b;
            sel_last  = wr_last_b;
            sel_req   = req_b;
            other_req = req_a;
            sel_addr  = addr_b;
            sel_data  = data_b;
        end
        // Counter saturates so an uncontested burst can run indefinitely
        cnt_next = burst_cnt_q;
        if (sel_valid && (burst_cnt_q != MAX_B)) begin
            cnt_next = burst_cnt_q + 8'd1;
        end
    end

    // Next-state, burst accounting and RAM write staging
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_cnt_d   = burst_cnt_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || (last_served_q == SERVED_B))) begin
                    state_d = GRANT_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                burst_cnt_d = cnt_next;
                if (sel_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = {write_bank, sel_addr};
                    ram_data_d = sel_data;
                end
                // The final write is still issued; release happens alongside it
                if ((sel_valid && sel_last) || !sel_req ||
                    ((cnt_next == MAX_B) && other_req)) begin
                    state_d       = IDLE;
                    last_served_d = (state_q == GRANT_B) ? SERVED_B : SERVED_A;
                    burst_cnt_d   = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter and RAM drive registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_served_q <= SERVED_B;
            burst_cnt_q   <= 8'd0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_cnt_q   <= burst_cnt_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
        end
    end

    assign grant_a          = (state_q == GRANT_A);
    assign grant_b          = (state_q == GRANT_B);
    assign ram_address      = ram_addr_q;
    assign ram_data_out     = ram_data_q;
    assign ram_write_enable = ram_we_q;
    assign ram_clk_enable   = ram_we_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with MAX_BURST=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Bank-swap scenarios depend on whether DOUBLE_BUFFER_EN is defined.
module tb_fb_write_arbiter;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0, wr_valid_a = 1'b0, wr_last_a = 1'b0;
    logic [11:0] addr_a = '0;
    logic [7:0]  data_a = '0;
    logic        grant_a;
    logic        req_b = 1'b0, wr_valid_b = 1'b0, wr_last_b = 1'b0;
    logic [11:0] addr_b = '0;
    logic [7:0]  data_b = '0;
    logic        grant_b;
    logic        frame_start = 1'b0, swap_request = 1'b0;
    logic        swap_pending, display_bank;
    logic [12:0] ram_address;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable, ram_clk_enable;

    int n_checks = 0;
    int n_errors = 0;
    logic wb;  // expected write bank for the tests before any swap

    fb_write_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk_in(clk_in), .reset(reset),
        .req_a(req_a), .wr_valid_a(wr_valid_a), .wr_last_a(wr_last_a),
        .addr_a(addr_a), .data_a(data_a), .grant_a(grant_a),
        .req_b(req_b), .wr_valid_b(wr_valid_b), .wr_last_b(wr_last_b),
        .addr_b(addr_b), .data_b(data_b), .grant_b(grant_b),
        .frame_start(frame_start), .swap_request(swap_request),
        .swap_pending(swap_pending), .display_bank(display_bank),
        .ram_address(ram_address), .ram_data_out(ram_data_out),
        .ram_write_enable(ram_write_enable), .ram_clk_enable(ram_clk_enable)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b0) begin n_errors++; $display("FAIL reset_grants: got a=%b b=%b want 0 0", grant_a, grant_b); end
        n_checks++; if (ram_write_enable !== 1'b0 || ram_clk_enable !== 1'b0) begin n_errors++; $display("FAIL reset_we: got we=%b ce=%b want 0 0", ram_write_enable, ram_clk_enable); end
        n_checks++; if (ram_address !== 13'h0 || ram_data_out !== 8'h0) begin n_errors++; $display("FAIL reset_ram: got addr=%h data=%h want 0 0", ram_address, ram_data_out); end
        n_checks++; if (swap_pending !== 1'b0 || display_bank !== 1'b0) begin n_errors++; $display("FAIL reset_bank: got pend=%b disp=%b want 0 0", swap_pending, display_bank); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_burst();
        logic [11:0] a_tab [3];
        logic [7:0]  d_tab [3];
        a_tab = '{12'h010, 12'h011, 12'h012};
        d_tab = '{8'h11, 8'h22, 8'h33};
        req_a = 1'b1;
        tick();
        n_checks++; if (grant_a !== 1'b1 || ram_write_enable !== 1'b0) begin n_errors++; $display("FAIL basic_grant: got grant=%b we=%b want 1 0", grant_a, ram_write_enable); end
        for (int i = 0; i < 3; i++) begin
            wr_valid_a = 1'b1; addr_a = a_tab[i]; data_a = d_tab[i]; wr_last_a = (i == 2);
            tick();
            n_checks++;
            if (ram_write_enable !== 1'b1 || ram_clk_enable !== 1'b1 || ram_address !== {wb, a_tab[i]} || ram_data_out !== d_tab[i]) begin
                n_errors++; $display("FAIL basic_write%0d: got we=%b addr=%h data=%h want 1 %h %h", i, ram_write_enable, ram_address, ram_data_out, {wb, a_tab[i]}, d_tab[i]);
            end
            n_checks++; if (grant_a !== (i != 2)) begin n_errors++; $display("FAIL basic_grant_hold%0d: got %b want %b", i, grant_a, (i != 2)); end
        end
        wr_valid_a = 1'b0; wr_last_a = 1'b0; req_a = 1'b0;
        tick();
        n_checks++; if (ram_write_enable !== 1'b0 || ram_address !== {wb, 12'h012} || ram_data_out !== 8'h33) begin n_errors++; $display("FAIL basic_hold: got we=%b addr=%h data=%h want 0 %h 33", ram_write_enable, ram_address, ram_data_out, {wb, 12'h012}); end
    endtask

    task automatic test_tie_after_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        tick();
        n_checks++; if (grant_a !== 1'b1 || grant_b !== 1'b0) begin n_errors++; $display("FAIL tie_first: got a=%b b=%b want 1 0", grant_a, grant_b); end
        wr_valid_a = 1'b1; wr_last_a = 1'b1; addr_a = 12'h020; data_a = 8'hA5;
        tick();
        n_checks++; if (grant_a !== 1'b0 || grant_b !== 1'b0 || ram_address !== {wb, 12'h020}) begin n_errors++; $display("FAIL tie_gap: got a=%b b=%b addr=%h want 0 0 %h", grant_a, grant_b, ram_address, {wb, 12'h020}); end
        wr_valid_a = 1'b0; wr_last_a = 1'b0; req_a = 1'b0;
        tick();
        n_checks++; if (grant_b !== 1'b1 || grant_a !== 1'b0) begin n_errors++; $display("FAIL tie_second: got a=%b b=%b want 0 1", grant_a, grant_b); end
        wr_valid_b = 1'b1; wr_last_b = 1'b1; addr_b = 12'h030; data_b = 8'h5A;
        tick();
        n_checks++; if (ram_write_enable !== 1'b1 || ram_address !== {wb, 12'h030} || ram_data_out !== 8'h5A || grant_b !== 1'b0) begin n_errors++; $display("FAIL tie_b_write: got we=%b addr=%h data=%h gb=%b want 1 %h 5a 0", ram_write_enable, ram_address, ram_data_out, grant_b, {wb, 12'h030}); end
        wr_valid_b = 1'b0; wr_last_b = 1'b0; req_b = 1'b0;
        tick();
    endtask

    task automatic test_burst_cap();
        int writes;
        writes = 0;
        req_a = 1'b1; req_b = 1'b1;   // last served was B, so A wins
        tick();
        n_checks++; if (grant_a !== 1'b1) begin n_errors++; $display("FAIL cap_grant: got %b want 1", grant_a); end
        for (int i = 0; i < 10; i++) begin
            wr_valid_a = 1'b1; addr_a = 12'h100 + 12'(i); data_a = 8'(i);
            tick();
            if (ram_write_enable === 1'b1) writes++;
            if (i == 3) begin
                n_checks++; if (grant_a !== 1'b0 || ram_address !== {wb, 12'h103}) begin n_errors++; $display("FAIL cap_release: got ga=%b addr=%h want 0 %h", grant_a, ram_address, {wb, 12'h103}); end
            end
            if (i == 4) begin
                n_checks++; if (grant_b !== 1'b1) begin n_errors++; $display("FAIL cap_b_grant: got %b want 1", grant_b); end
            end
        end
        wr_valid_a = 1'b0;
        n_checks++; if (writes != 4) begin n_errors++; $display("FAIL cap_count: got %0d writes want 4", writes); end
        req_b = 1'b0;
        tick();
        n_checks++; if (grant_b !== 1'b0 || grant_a !== 1'b0) begin n_errors++; $display("FAIL cap_b_drop: got a=%b b=%b want 0 0", grant_a, grant_b); end
        tick();
        n_checks++; if (grant_a !== 1'b1) begin n_errors++; $display("FAIL cap_regrant_a: got %b want 1", grant_a); end
        req_a = 1'b0;
        tick(); tick();
    endtask

    task automatic test_ignore_other();
        req_a = 1'b1;
        tick();
        wr_valid_b = 1'b1; addr_b = 12'h3FF; data_b = 8'hEE;
        tick();
        n_checks++; if (ram_write_enable !== 1'b0) begin n_errors++; $display("FAIL ignore_b_we: got %b want 0", ram_write_enable); end
        wr_valid_a = 1'b1; wr_last_a = 1'b1; addr_a = 12'h040; data_a = 8'h77;
        tick();
        n_checks++; if (ram_write_enable !== 1'b1 || ram_address !== {wb, 12'h040} || ram_data_out !== 8'h77) begin n_errors++; $display("FAIL ignore_a_write: got we=%b addr=%h data=%h want 1 %h 77", ram_write_enable, ram_address, ram_data_out, {wb, 12'h040}); end
        wr_valid_a = 1'b0; wr_last_a = 1'b0; req_a = 1'b0; wr_valid_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_saturate();
        int writes;
        writes = 0;
        req_a = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            wr_valid_a = 1'b1; addr_a = 12'h200 + 12'(i); data_a = 8'h80 + 8'(i);
            tick();
            if (ram_write_enable === 1'b1) writes++;
        end
        n_checks++; if (writes != 6 || grant_a !== 1'b1) begin n_errors++; $display("FAIL sat_stream: got %0d writes ga=%b want 6 1", writes, grant_a); end
        wr_valid_a = 1'b0; req_b = 1'b1;
        tick();
        n_checks++; if (grant_a !== 1'b0) begin n_errors++; $display("FAIL sat_release: got %b want 0", grant_a); end
        tick();
        n_checks++; if (grant_b !== 1'b1) begin n_errors++; $display("FAIL sat_b_grant: got %b want 1", grant_b); end
        req_a = 1'b0; req_b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_swap();
`ifdef DOUBLE_BUFFER_EN
        swap_request = 1'b1; tick(); swap_request = 1'b0;
        n_checks++; if (swap_pending !== 1'b1) begin n_errors++; $display("FAIL swap_latch: got %b want 1", swap_pending); end
        req_a = 1'b1; tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++; if (display_bank !== 1'b0 || swap_pending !== 1'b1) begin n_errors++; $display("FAIL swap_defer: got disp=%b pend=%b want 0 1", display_bank, swap_pending); end
        wr_valid_a = 1'b1; wr_last_a = 1'b1; addr_a = 12'h050; data_a = 8'h99;
        tick();
        n_checks++; if (ram_address !== 13'h1050) begin n_errors++; $display("FAIL swap_back_bank: got %h want 1050", ram_address); end
        wr_valid_a = 1'b0; wr_last_a = 1'b0; req_a = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++; if (display_bank !== 1'b1 || swap_pending !== 1'b0) begin n_errors++; $display("FAIL swap_apply: got disp=%b pend=%b want 1 0", display_bank, swap_pending); end
        req_a = 1'b1; tick();
        wr_valid_a = 1'b1; wr_last_a = 1'b1; addr_a = 12'h051; data_a = 8'h9A;
        tick();
        n_checks++; if (ram_address !== 13'h0051) begin n_errors++; $display("FAIL swap_new_bank: got %h want 0051", ram_address); end
        wr_valid_a = 1'b0; wr_last_a = 1'b0; req_a = 1'b0;
        tick();
        swap_request = 1'b1; frame_start = 1'b1; tick(); swap_request = 1'b0; frame_start = 1'b0;
        n_checks++; if (display_bank !== 1'b1 || swap_pending !== 1'b1) begin n_errors++; $display("FAIL swap_same_cycle: got disp=%b pend=%b want 1 1", display_bank, swap_pending); end
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++; if (display_bank !== 1'b0 || swap_pending !== 1'b0) begin n_errors++; $display("FAIL swap_back: got disp=%b pend=%b want 0 0", display_bank, swap_pending); end
`else
        swap_request = 1'b1; tick(); swap_request = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        n_checks++; if (display_bank !== 1'b0 || swap_pending !== 1'b0) begin n_errors++; $display("FAIL swap_disabled: got disp=%b pend=%b want 0 0", display_bank, swap_pending); end
`endif
    endtask

    task automatic test_reset_mid_burst();
`ifdef DOUBLE_BUFFER_EN
        swap_request = 1'b1; tick(); swap_request = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        swap_request = 1'b1; tick(); swap_request = 1'b0;
`endif
        req_a = 1'b1; tick();
        wr_valid_a = 1'b1; addr_a = 12'h060; data_a = 8'h66;
        tick();
        n_checks++; if (ram_write_enable !== 1'b1 || grant_a !== 1'b1) begin n_errors++; $display("FAIL mid_pre: got we=%b ga=%b want 1 1", ram_write_enable, grant_a); end
        reset = 1'b1;
        #1;
        n_checks++; if (grant_a !== 1'b0 || ram_write_enable !== 1'b0 || swap_pending !== 1'b0 || display_bank !== 1'b0 || ram_address !== 13'h0) begin
            n_errors++; $display("FAIL mid_reset: got ga=%b we=%b pend=%b disp=%b addr=%h want 0 0 0 0 0", grant_a, ram_write_enable, swap_pending, display_bank, ram_address);
        end
        req_a = 1'b0; wr_valid_a = 1'b0;
        tick(); reset = 1'b0; tick();
    endtask

    initial begin
`ifdef DOUBLE_BUFFER_EN
        wb = 1'b1;
`else
        wb = 1'b0;
`endif
        test_reset();
        test_basic_burst();
        test_tie_after_reset();
        test_burst_cap();
        test_ignore_other();
        test_saturate();
        test_swap();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
